// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: data width, opcodes and the
// issue-controller state encoding.
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_CMP   = 3'b110;
    localparam logic [2:0] OP_LOADI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational operand reads, a debug read,
// one synchronous write, cleared asynchronously by rst_n.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Each word is its own register so the whole file can clear asynchronously.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign mem[gi] = word_reg;
        end
    endgenerate

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 4-bit ALU: latches operands from the
// register file, writes the ALU result back and returns it over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_dst,
    input  logic [AW-1:0]     in_sa,
    input  logic [AW-1:0]     in_sb,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_carry,
    output logic [AW-1:0]     out_dst,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [2:0]        alu_opcode_reg;
    logic [DATA_W-1:0] out_result_reg;
    logic              out_zero_reg;
    logic              out_carry_reg;
    logic              out_valid_reg;
    logic [AW-1:0]     out_dst_reg;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    // Writeback lands in EXEC, so the next IDLE read always sees it.
    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state_reg == ST_EXEC),
        .waddr    (out_dst_reg),
        .wdata    (alu_result),
        .ra_addr  (in_sa),
        .ra_data  (rf_a),
        .rb_addr  (in_sb),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_opcode_reg <= '0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_carry_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_dst_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_dst_reg <= in_dst;
                        // LOADI is routed through the ALU as imm | 0.
                        if (in_op == OP_LOADI) begin
                            alu_a_reg      <= in_imm;
                            alu_b_reg      <= '0;
                            alu_opcode_reg <= OP_OR;
                        end else begin
                            alu_a_reg      <= rf_a;
                            alu_b_reg      <= rf_b;
                            alu_opcode_reg <= in_op;
                        end
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_result_reg <= alu_result;
                    out_zero_reg   <= alu_zero;
                    out_carry_reg  <= alu_carry;
                    out_valid_reg  <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_opcode = alu_opcode_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_carry  = out_carry_reg;
    assign out_dst    = out_dst_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural 4-bit ALU stands in for alu_4bit,
// and an array model of the register file predicts every response.
module tb_alu_issue_ctrl;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [1:0] in_dst = '0, in_sa = '0, in_sb = '0;
    logic [3:0] in_imm = '0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero, alu_carry;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_zero, out_carry;
    logic [1:0] out_dst;
    logic [1:0] dbg_addr = '0;
    logic [3:0] dbg_data;

    int errors = 0;
    int checks = 0;
    logic [3:0] model_rf [NR];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_sa(in_sa), .in_sb(in_sb), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_carry(out_carry), .out_dst(out_dst),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in for alu_4bit (carry on SUB is the borrow).
    always_comb begin
        logic [4:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = 1'b0;
        case (alu_opcode)
            3'b000: begin alu_result = sum[3:0]; alu_carry = sum[4]; end
            3'b001: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~alu_a;
            3'b110: alu_result = (alu_a > alu_b) ? 4'd1 : 4'd0;
            default: alu_result = 4'd0;
        endcase
        alu_zero = (alu_result == 4'd0);
    end

    // Reference: what an instruction should produce, from integer arithmetic.
    function automatic void predict(input logic [2:0] op, input int sa, input int sb,
                                    input logic [3:0] imm, output int res, output int cy);
        int a, b;
        a = int'(model_rf[sa]);
        b = int'(model_rf[sb]);
        cy = 0;
        case (op)
            3'd0: begin res = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
            3'd1: begin res = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = 15 - a;
            3'd6: res = (a > b) ? 1 : 0;
            default: res = int'(imm);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) model_rf[i] = 4'd0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if ({alu_a, alu_b, alu_opcode} !== 11'd0) begin errors++; $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_opcode}); end
        checks++; if ({out_result, out_zero, out_carry, out_dst} !== 8'd0) begin errors++; $display("FAIL reset_payload got=%h want=0", {out_result, out_zero, out_carry, out_dst}); end
        for (int i = 0; i < NR; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++; if (dbg_data !== 4'd0) begin errors++; $display("FAIL reset_rf%0d got=%h want=0", i, dbg_data); end
        end
    endtask

    // Issue one instruction, hold the response for `stall` cycles, then consume it.
    task automatic run_instr(input logic [2:0] op, input int dst, input int sa, input int sb,
                             input logic [3:0] imm, input int stall);
        int res, cy, w;
        logic [3:0] ea, eb;
        logic [2:0] eop;
        predict(op, sa, sb, imm, res, cy);
        ea  = (op == 3'd7) ? imm  : model_rf[sa];
        eb  = (op == 3'd7) ? 4'd0 : model_rf[sb];
        eop = (op == 3'd7) ? 3'd3 : op;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_dst = 2'(dst); in_sa = 2'(sa); in_sb = 2'(sb); in_imm = imm;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout op=%0d got in_ready=%b want=1", op, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({alu_a, alu_b, alu_opcode} !== {ea, eb, eop}) begin errors++; $display("FAIL alu_drive op=%0d got=%h/%h/%0d want=%h/%h/%0d", op, alu_a, alu_b, alu_opcode, ea, eb, eop); end
        checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL exec_flags got rdy/vld=%b%b want=00", in_ready, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL resp_latency got out_valid=%b want=1", out_valid); end
        for (int s = 0; s <= stall; s++) begin
            checks++; if ({out_result, out_zero, out_carry, out_dst} !== {4'(res), (res == 0), 1'(cy), 2'(dst)})
                begin errors++; $display("FAIL resp_payload op=%0d cyc=%0d got r=%h z=%b c=%b d=%0d want r=%h z=%b c=%b d=%0d",
                    op, s, out_result, out_zero, out_carry, out_dst, res, (res == 0), cy, dst); end
            checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL resp_hold cyc=%0d got rdy/vld=%b%b want=01", s, in_ready, out_valid); end
            if (s < stall) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_rf[dst] = 4'(res);
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL after_handshake got rdy/vld=%b%b want=10", in_ready, out_valid); end
        dbg_addr = 2'(dst);
        #1;
        checks++; if (dbg_data !== model_rf[dst]) begin errors++; $display("FAIL writeback r%0d got=%h want=%h", dst, dbg_data, model_rf[dst]); end
        $display("instr op=%0d dst=r%0d sa=r%0d sb=r%0d imm=%h -> result=%h carry=%0d stall=%0d", op, dst, sa, sb, imm, res, cy, stall);
    endtask

    task automatic test_add_carry();
        run_instr(3'd7, 1, 0, 0, 4'd9, 0);
        run_instr(3'd7, 2, 0, 0, 4'd8, 0);
        run_instr(3'd0, 3, 1, 2, 4'd0, 0);
        checks++; if ({out_result, out_carry, out_zero, out_dst} !== {4'b0001, 1'b1, 1'b0, 2'd3})
            begin errors++; $display("FAIL add_carry got r=%h c=%b z=%b d=%0d want r=1 c=1 z=0 d=3", out_result, out_carry, out_zero, out_dst); end
    endtask

    task automatic test_sub();
        run_instr(3'd1, 0, 2, 2, 4'd0, 0);
        checks++; if ({out_result, out_zero, out_carry} !== {4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_zero got r=%h z=%b c=%b want r=0 z=1 c=0", out_result, out_zero, out_carry); end
        run_instr(3'd1, 0, 2, 1, 4'd0, 1);
        checks++; if ({out_result, out_carry} !== {4'hF, 1'b1}) begin errors++; $display("FAIL sub_borrow got r=%h c=%b want r=f c=1", out_result, out_carry); end
    endtask

    task automatic test_backpressure();
        int res, cy;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd7; in_dst = 2'd0; in_sa = 2'd0; in_sb = 2'd0; in_imm = 4'd5;
        @(negedge clk);
        // second instruction waits on in_valid throughout the stall
        in_op = 3'd0; in_dst = 2'd3; in_sa = 2'd1; in_sb = 2'd2; in_imm = 4'd0;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            checks++; if ({out_valid, in_ready, out_result, alu_a} !== {1'b1, 1'b0, 4'd5, 4'd5})
                begin errors++; $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b r=%h a=%h want 1 0 5 5", s, out_valid, in_ready, out_result, alu_a); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_rf[0] = 4'd5;
        checks++; if ({out_valid, in_ready, alu_opcode} !== {1'b0, 1'b1, 3'd3}) begin errors++; $display("FAIL bp_release got vld=%b rdy=%b op=%0d want 0 1 3", out_valid, in_ready, alu_opcode); end
        @(negedge clk);
        in_valid = 1'b0;
        predict(3'd0, 1, 2, 4'd0, res, cy);
        checks++; if ({alu_a, alu_b, alu_opcode, in_ready} !== {model_rf[1], model_rf[2], 3'd0, 1'b0})
            begin errors++; $display("FAIL bp_second_accept got a=%h b=%h op=%0d rdy=%b want a=%h b=%h op=0 rdy=0", alu_a, alu_b, alu_opcode, in_ready, model_rf[1], model_rf[2]); end
        @(negedge clk);
        checks++; if ({out_valid, out_result, out_carry, out_dst} !== {1'b1, 4'(res), 1'(cy), 2'd3})
            begin errors++; $display("FAIL bp_second_resp got vld=%b r=%h c=%b d=%0d want 1 %h %0d 3", out_valid, out_result, out_carry, out_dst, res, cy); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_rf[3] = 4'(res);
        $display("backpressure: held 5 cycles, pending ADD r3 accepted after handshake -> %h", res);
    endtask

    task automatic test_cmp_alias();
        run_instr(3'd6, 1, 1, 2, 4'd0, 0);
        checks++; if ({out_result, out_zero} !== {4'd1, 1'b0}) begin errors++; $display("FAIL cmp_gt got r=%h z=%b want r=1 z=0", out_result, out_zero); end
        run_instr(3'd6, 1, 1, 2, 4'd0, 0);
        checks++; if ({out_result, out_zero} !== {4'd0, 1'b1}) begin errors++; $display("FAIL cmp_alias got r=%h z=%b want r=0 z=1", out_result, out_zero); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_dst = 2'd3; in_sa = 2'd0; in_sb = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, alu_a} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL async_reset got rdy=%b vld=%b a=%h want 1 0 0", in_ready, out_valid, alu_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) model_rf[i] = 4'd0;
        for (int s = 0; s < 4; s++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard cyc=%0d got out_valid=%b want=0", s, out_valid); end
            @(negedge clk);
        end
        dbg_addr = 2'd3;
        #1;
        checks++; if (dbg_data !== 4'd0) begin errors++; $display("FAIL reset_r3 got=%h want=0", dbg_data); end
        $display("mid-op reset: ADD r3 discarded");
        run_instr(3'd7, 2, 0, 0, 4'd6, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom_range(0, 7)), int'($urandom_range(0, NR - 1)),
                      int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_backpressure();
        test_cmp_alias();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Operand/issue controller that sits directly upstream of the 4-bit ALU (`alu_4bit`). It accepts register-level instructions over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU's A, B and opcode inputs from registers, writes the result back to the destination register, and returns result plus flags over a second valid/ready handshake.

## Interface
- `NUM_REGS`, default 4: register-file depth; must be a power of 2, at least 2.
- `AW`, default $clog2(NUM_REGS): register address width; derived, not overridden.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: instruction accepted when `in_valid & in_ready` is high at a rising edge.
- `in_op` input 3: ALU opcode 000..110; 111 = LOADI.
- `in_dst`, `in_sa`, `in_sb` input AW each: destination, source A and source B register indices.
- `in_imm` input 4: immediate, used by LOADI only.
- `alu_a`, `alu_b` output 4: registered operands to the ALU.
- `alu_opcode` output 3: registered opcode to the ALU.
- `alu_result` input 4, `alu_zero` input 1, `alu_carry` input 1: combinational ALU outputs.
- `out_valid` output 1: response available.
- `out_ready` input 1: response consumed when `out_valid & out_ready` is high.
- `out_result` output 4, `out_zero` output 1, `out_carry` output 1, `out_dst` output AW: response payload.
- `dbg_addr` input AW, `dbg_data` output 4: combinational register-file read port for the testbench.

## Operation
- The interface is as decided: one clock; reset is asynchronous and active-low.
- State machine with three states: IDLE, EXEC, RESP.
- IDLE:
  - `in_ready` is 1.
  - On accept, capture `alu_opcode` and `out_dst` from `in_dst`, then go to EXEC.
  - ALU op (000..110): `alu_a` ← rf[`in_sa`], `alu_b` ← rf[`in_sb`], `alu_opcode` ← `in_op`.
  - LOADI (111): `alu_a` ← `in_imm`, `alu_b` ← 0, `alu_opcode` ← 011 (OR). The ALU then returns `imm` with the correct zero flag and carry 0.
- EXEC:
  - `in_ready` is 0.
  - At the clock edge: rf[dst] ← `alu_result`, `out_result` ← `alu_result`, `out_zero` ← `alu_zero`, `out_carry` ← `alu_carry`. Then go to RESP.
- RESP:
  - `out_valid` is 1 and `in_ready` is 0.
  - On `out_ready`, drop `out_valid` and go to IDLE.
  - Payload and `alu_*` outputs hold stable while `out_valid` is high and `out_ready` is low.
- `in_valid` is ignored outside IDLE; no instruction is dropped because `in_ready` is low.
- Operand reads in IDLE always observe the previous instruction's writeback, since writeback happens in EXEC, two or more cycles earlier. No forwarding is needed.
- A destination equal to a source is legal: the source value is latched at accept, and the write happens in EXEC.
- Arithmetic is performed entirely by the ALU. This block does no width extension; all data is 4 bits, and carry/borrow come from the ALU unchanged.

## Timing
- Accept at edge N. `alu_*` are valid after edge N. The register file and payload update at edge N+1. `out_valid` is high from edge N+1.
- The earliest response is 1 cycle after accept. With `out_ready` tied high, throughput is 1 instruction per 3 cycles.
- Reset values:
  - state IDLE
  - all rf entries 0
  - `alu_a`, `alu_b`, `alu_opcode`, `out_result`, `out_dst` = 0
  - `out_zero`, `out_carry`, `out_valid` = 0
  - `in_ready` = 1 once `rst_n` is high
- Reset asserted in EXEC or RESP:
  - Reset takes effect immediately and asynchronously.
  - The in-flight instruction is discarded: no writeback and no `out_valid`.
  - The register file is cleared.
- Releasing `rst_n` is expected synchronous to `clk`; reset synchronisation is done outside this block.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_CMP=110, OP_LOADI=111
  - the state encoding for IDLE/EXEC/RESP
  - DATA_W=4
- One natural sub-module: `alu_regfile`.
  - NUM_REGS×4 bits.
  - Two combinational read ports plus the `dbg` read port.
  - One synchronous write port; asynchronous clear on `rst_n`.
- The FSM and the response registers stay in `alu_issue_ctrl`. The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset: after `rst_n` deasserts, all outputs are 0, `in_ready`=1, and `dbg_data` is 0 for every address.
- ADD with carry: LOADI r1=9, LOADI r2=8, then ADD r3=r1+r2. Expect `out_result`=0001, `out_carry`=1, `out_zero`=0, `out_dst`=3, and `dbg` r3=0001.
- SUB: SUB r0=r2−r2 gives `out_result`=0000, `out_zero`=1, `out_carry`=0. SUB r0=r2−r1 (8−9) gives 1111 with `out_carry`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. `out_valid` and the payload stay stable, `in_ready`=0, and a pending `in_valid` is not accepted until the cycle after the handshake.
- CMP and aliasing:
  - CMP r1=r1>r2 with 9>8 returns 0001 and r1 becomes 0001.
  - A following CMP r1>r2 reads the new r1 and returns 0000 with `out_zero`=1.
- Mid-operation reset: pulse `rst_n` low during EXEC of ADD r3. No `out_valid` follows, r3=0, and the next accepted instruction completes normally.
